// File: rtl/bcd_convert_scheduler_pkg.sv
// ============================================================================
// bcd_sched_pkg : shared types and the double-dabble digit adjust helper
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_sched_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [DIGIT_W-1:0] add3_digit(input logic [DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_convert_scheduler_if.sv
// ============================================================================
// bcd_convert_scheduler_if : requester/result bus of the BCD conversion scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface bcd_convert_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int DIGITS  = 3
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DIGITS*4-1:0] bcd_out;
    logic [NUM_REQ-1:0]          bcd_valid;
    logic [NUM_REQ-1:0]          done;
    logic                        busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, bcd_out, bcd_valid, done, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, bcd_out, bcd_valid, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/bcd_convert_scheduler_core.sv
// ============================================================================
// bcd_dabble_core : serial double-dabble engine, one conversion per start pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_core
    import bcd_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start_i,
    input  wire logic [DATA_W-1:0]         data_i,
    output logic                           last_o,
    output logic [DIGITS*DIGIT_W-1:0]      bcd_o
);
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SR_W-1:0]  sr_q, sr_d, adj;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            adj[DATA_W + i*DIGIT_W +: DIGIT_W] = add3_digit(sr_q[DATA_W + i*DIGIT_W +: DIGIT_W]);
        end
        sr_d = sr_q;
        if (start_i) begin
            sr_d = {{BCD_W{1'b0}}, data_i};
        end else if (active_q) begin
            sr_d = adj << 1;
        end
    end

    assign last_o = active_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign bcd_o  = sr_q[SR_W-1 -: BCD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q <= sr_d;
            if (start_i) begin
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                cnt_q <= cnt_q + 1'b1;
                if (last_o) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_convert_scheduler.sv
// ============================================================================
// bcd_convert_scheduler : round-robin sharing of one BCD engine, per-channel results
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_convert_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int DIGITS  = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    bcd_convert_scheduler_if.slave bus
);
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, gid_q, gid_w;
    logic [NUM_REQ-1:0] grant;
    logic               found, hs, wr, core_last;
    logic [DATA_W-1:0]  data_sel;
    logic [BCD_W-1:0]   core_bcd;
    int                 idx;

    // Search rr_ptr, rr_ptr+1, ... so the channel after the last winner goes first
    always_comb begin
        grant = '0;
        gid_w = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == idx && !found && bus.req_valid[j]) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    gid_w    = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == gid_w) data_sel = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign hs            = found && (state_q == ST_IDLE) && !rst;
    assign wr            = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs) state_d = ST_SHIFT;
            ST_SHIFT: if (core_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
        end else begin
            state_q <= state_d;
            if (hs) gid_q <= gid_w;
            if (wr) rr_ptr_q <= (gid_q == PTR_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        end
    end

    bcd_dabble_core #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (hs),
        .data_i  (data_sel),
        .last_o  (core_last),
        .bcd_o   (core_bcd)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ch
        logic [BCD_W-1:0] bcd_q;
        logic             valid_q;
        logic             done_q;
        logic             sel;

        assign sel = wr && (gid_q == PTR_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                bcd_q   <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= sel;
                if (sel) begin
                    bcd_q   <= core_bcd;
                    valid_q <= 1'b1;
                end
            end
        end

        assign bus.bcd_out[g*BCD_W +: BCD_W] = bcd_q;
        assign bus.bcd_valid[g]              = valid_q;
        assign bus.done[g]                   = done_q;
    end

endmodule

`default_nettype wire
